hysteresis_counter_table_controller: RTL and testbench
======================================================

# hysteresis_counter_table_controller

Owns a table of DEPTH hysteresis saturating counters, each with a single write port. It shares the table between two update requesters (A, B) using round-robin arbitration with same-index merging, and applies updates through a one-stage pipeline. It also serves a combinational read port and sequences a table-clear walk. It sits between the predictor/training logic and the counter storage.

## Interface
- DEPTH, 8, number of counters
- DEPTH_LOG2, clog2(DEPTH), index width
- RANGE, 4, counter range; values 0..RANGE-1; even, ≥4
- RANGE_LOG2, clog2(RANGE), counter width
- RESET_VALUE, 1, counter value after reset or clear
- COERCIVITY, 1, hysteresis jump width; must satisfy RANGE/2-1-COERCIVITY ≥ 0
- clock  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- update_a_valid / update_b_valid  in  1  update request
- update_a_ready / update_b_ready  out  1  update accepted when valid&ready
- update_a_index / update_b_index  in  DEPTH_LOG2  counter to update
- update_a_up / update_b_up  in  1  1 = increment, 0 = decrement
- read_index  in  DEPTH_LOG2  read address
- read_count  out  RANGE_LOG2  counter value at read_index (combinational)
- read_high  out  1  read_count ≥ RANGE/2
- clear  in  1  start clear walk (pulse)
- busy  out  1  drain/clear in progress

## Operation
- Step function, with saturation at 0 and RANGE-1:
  - Increment from RANGE/2-1 goes to RANGE/2+COERCIVITY; otherwise +1.
  - Decrement from RANGE/2 goes to RANGE/2-1-COERCIVITY; otherwise -1.
- Arbitration (IDLE only):
  - Only one valid: it is granted.
  - Both valid, different indices: the priority holder is granted; the other sees ready=0.
  - Both valid, same index: both granted. Same direction applies one step; opposite directions apply no change (stage still loaded).
  - Priority toggles after every contended single grant; initial priority is A.
- Pipeline:
  - A granted update computes the new value from the base value and loads stage {valid, index, value}.
  - The stage writes the table on the next edge.
  - Base value is the stage value when stage is valid and stage index equals the request index; otherwise it is the table entry. This forwarding is mandatory and independent of the configuration macro.
- Ready: update_x_ready = (state==IDLE) && !clear && arbitration grant.
- FSM:
  - IDLE --clear--> DRAIN. The clear edge does not load the stage.
  - DRAIN writes any pending stage (one cycle) --> CLEAR.
  - CLEAR writes RESET_VALUE to index walk_idx, incrementing from 0. The cycle that writes DEPTH-1 transitions to IDLE.
  - clear is ignored outside IDLE.
- busy = state != IDLE.
- Reset:
  - All entries = RESET_VALUE; stage invalid; state IDLE; priority A; walk_idx 0.
  - Outputs: ready 0 during reset, busy 0, read_count = RESET_VALUE.
  - Reset mid-walk aborts the walk.

## Timing
- Update accepted in cycle N: stage loaded at end of N; table written at end of N+1.
- read_count of that index: new value at N+1 with bypass; at N+2 without.
- Back-to-back updates to one index in N, N+1 chain correctly via forwarding.
- Clear asserted in cycle N: busy from N+1; IDLE again at N+2+DEPTH; updates accepted from that cycle.

## Configuration
- HYSTERESIS_COUNTER_TABLE_READ_BYPASS_EN defined: read_count returns the stage value when stage is valid and stage index equals read_index.
- Not defined: read_count always returns the table entry (one cycle stale after an update).

## Structure
- Shared package hysteresis_counter_table_pkg holds:
  - FSM state encodings IDLE/DRAIN/CLEAR.
  - Derived constants COUNTER_HALF_LOW, COUNTER_HALF_HIGH, COUNTER_JUMP_LOW, COUNTER_JUMP_HIGH.
- Sub-module hysteresis_counter_step: combinational step function (value, increment, decrement → next value), parameterised by RANGE/COERCIVITY.

## Test plan
- Reset, then A increments index 3 four times (RANGE 4, COERCIVITY 1, RESET 1) → count sequence 1→3→3→3 (jump from 1 to 3, then saturation); read_high=1.
- From 3, two decrements of index 3 → 2 then 0 (jump from 2 to 0); further decrements hold 0.
- A and B both valid, indices 2 and 5, for 4 cycles → grants alternate A,B,A,B; ready of the loser is 0.
- A up and B down on index 4, same cycle → both ready=1; index 4 unchanged. Both up → single step.
- Update index 6 accepted in cycle N, read_index=6 → new value at N+1 with the macro defined; at N+2 without it.
- clear in cycle N with a pending stage, DEPTH 8 → busy at N+1..N+9, all entries read 1 at N+10, updates blocked meanwhile. Reset asserted at walk index 4 → immediate IDLE, all entries 1.

Source files
------------

// File: rtl/hysteresis_counter_table_pkg.sv
// Shared types and derived constants for the hysteresis counter table.
// FSM state encoding plus helpers that derive the hysteresis thresholds from RANGE/COERCIVITY.
package hysteresis_counter_table_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } table_state_t;

  localparam int DEFAULT_RANGE      = 4;
  localparam int DEFAULT_COERCIVITY = 1;

  function automatic int counter_half_low(input int range);
    return range / 2 - 1;
  endfunction

  function automatic int counter_half_high(input int range);
    return range / 2;
  endfunction

  function automatic int counter_jump_low(input int range, input int coercivity);
    return range / 2 - 1 - coercivity;
  endfunction

  function automatic int counter_jump_high(input int range, input int coercivity);
    return range / 2 + coercivity;
  endfunction

  localparam int COUNTER_HALF_LOW  = counter_half_low(DEFAULT_RANGE);
  localparam int COUNTER_HALF_HIGH = counter_half_high(DEFAULT_RANGE);
  localparam int COUNTER_JUMP_LOW  = counter_jump_low(DEFAULT_RANGE, DEFAULT_COERCIVITY);
  localparam int COUNTER_JUMP_HIGH = counter_jump_high(DEFAULT_RANGE, DEFAULT_COERCIVITY);

endpackage

// File: rtl/hysteresis_counter_table_controller_if.sv
// Requester-facing bundle of the counter table: two update handshakes, read port, clear/busy.
// master = predictor/training side, slave = the table controller.
interface hysteresis_counter_table_controller_if #(
  parameter int DEPTH_LOG2 = 3,
  parameter int RANGE_LOG2 = 2
);
  logic                  update_a_valid;
  logic                  update_a_ready;
  logic [DEPTH_LOG2-1:0] update_a_index;
  logic                  update_a_up;
  logic                  update_b_valid;
  logic                  update_b_ready;
  logic [DEPTH_LOG2-1:0] update_b_index;
  logic                  update_b_up;
  logic [DEPTH_LOG2-1:0] read_index;
  logic [RANGE_LOG2-1:0] read_count;
  logic                  read_high;
  logic                  clear;
  logic                  busy;

  modport master (
    output update_a_valid, update_a_index, update_a_up,
    output update_b_valid, update_b_index, update_b_up,
    output read_index, clear,
    input  update_a_ready, update_b_ready, read_count, read_high, busy
  );

  modport slave (
    input  update_a_valid, update_a_index, update_a_up,
    input  update_b_valid, update_b_index, update_b_up,
    input  read_index, clear,
    output update_a_ready, update_b_ready, read_count, read_high, busy
  );
endinterface

// File: rtl/hysteresis_counter_step.sv
// Combinational hysteresis step: saturating +/-1 with a jump across the midpoint.
// Increment and decrement together (or neither) leave the value unchanged.
module hysteresis_counter_step
  import hysteresis_counter_table_pkg::*;
#(
  parameter int RANGE      = 4,
  parameter int COERCIVITY = 1,
  parameter int RANGE_LOG2 = $clog2(RANGE)
) (
  input  logic [RANGE_LOG2-1:0] value,
  input  logic                  increment,
  input  logic                  decrement,
  output logic [RANGE_LOG2-1:0] next_value
);

  localparam logic [RANGE_LOG2-1:0] MAX_VALUE = RANGE_LOG2'(RANGE - 1);
  localparam logic [RANGE_LOG2-1:0] HALF_LOW  = RANGE_LOG2'(counter_half_low(RANGE));
  localparam logic [RANGE_LOG2-1:0] HALF_HIGH = RANGE_LOG2'(counter_half_high(RANGE));
  localparam logic [RANGE_LOG2-1:0] JUMP_LOW  = RANGE_LOG2'(counter_jump_low(RANGE, COERCIVITY));
  localparam logic [RANGE_LOG2-1:0] JUMP_HIGH = RANGE_LOG2'(counter_jump_high(RANGE, COERCIVITY));

  always_comb begin
    next_value = value;
    if (increment && !decrement) begin
      if (value == HALF_LOW)
        next_value = JUMP_HIGH;
      else if (value != MAX_VALUE)
        next_value = value + RANGE_LOG2'(1);
    end else if (decrement && !increment) begin
      if (value == HALF_HIGH)
        next_value = JUMP_LOW;
      else if (value != '0)
        next_value = value - RANGE_LOG2'(1);
    end
  end

endmodule

// File: rtl/hysteresis_counter_table_controller.sv
// Table of hysteresis counters shared by two round-robin requesters through a one-stage update pipeline.
// Optional macro HYSTERESIS_COUNTER_TABLE_READ_BYPASS_EN forwards the pending stage to the read port.
module hysteresis_counter_table_controller
  import hysteresis_counter_table_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int DEPTH_LOG2  = $clog2(DEPTH),
  parameter int RANGE       = DEFAULT_RANGE,
  parameter int RANGE_LOG2  = $clog2(RANGE),
  parameter int RESET_VALUE = 1,
  parameter int COERCIVITY  = DEFAULT_COERCIVITY
) (
  input logic clock,
  input logic reset,
  hysteresis_counter_table_controller_if.slave bus
);

  localparam logic [RANGE_LOG2-1:0] RESET_COUNT = RANGE_LOG2'(RESET_VALUE);
  localparam logic [RANGE_LOG2-1:0] HIGH_LIMIT  = RANGE_LOG2'(counter_half_high(RANGE));
  localparam logic [DEPTH_LOG2-1:0] LAST_INDEX  = DEPTH_LOG2'(DEPTH - 1);

  table_state_t state, next_state;

  logic [RANGE_LOG2-1:0] counters [DEPTH];
  logic                  stage_valid;
  logic [DEPTH_LOG2-1:0] stage_index;
  logic [RANGE_LOG2-1:0] stage_value;
  logic [DEPTH_LOG2-1:0] walk_idx;
  logic                  priority_b;
  logic                  walk_done;

  logic                  accepting;
  logic                  same_index;
  logic                  fire_a;
  logic                  fire_b;
  logic                  contended;
  logic [DEPTH_LOG2-1:0] req_index;
  logic                  req_up;
  logic                  req_down;
  logic [RANGE_LOG2-1:0] base_value;
  logic [RANGE_LOG2-1:0] new_value;
  logic [RANGE_LOG2-1:0] read_value;
  logic                  busy_flag;

  assign walk_done = (walk_idx == LAST_INDEX);

  always_comb begin
    same_index = (bus.update_a_index == bus.update_b_index);
    accepting  = (state == IDLE) && !bus.clear && !reset;
    fire_a     = accepting && bus.update_a_valid &&
                 (!bus.update_b_valid || same_index || !priority_b);
    fire_b     = accepting && bus.update_b_valid &&
                 (!bus.update_a_valid || same_index || priority_b);
    contended  = bus.update_a_valid && bus.update_b_valid && (fire_a != fire_b);
  end

  assign bus.update_a_ready = fire_a;
  assign bus.update_b_ready = fire_b;

  // A merged same-index pair steps once if the directions agree and cancels otherwise.
  always_comb begin
    req_index = fire_a ? bus.update_a_index : bus.update_b_index;
    req_up    = 1'b0;
    req_down  = 1'b0;
    if (fire_a && fire_b) begin
      req_up   = bus.update_a_up && bus.update_b_up;
      req_down = !bus.update_a_up && !bus.update_b_up;
    end else if (fire_a) begin
      req_up   = bus.update_a_up;
      req_down = !bus.update_a_up;
    end else if (fire_b) begin
      req_up   = bus.update_b_up;
      req_down = !bus.update_b_up;
    end
    base_value = (stage_valid && stage_index == req_index) ? stage_value
                                                           : counters[req_index];
  end

  hysteresis_counter_step #(
    .RANGE      (RANGE),
    .COERCIVITY (COERCIVITY),
    .RANGE_LOG2 (RANGE_LOG2)
  ) step (
    .value      (base_value),
    .increment  (req_up),
    .decrement  (req_down),
    .next_value (new_value)
  );

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.clear) next_state = DRAIN;
      DRAIN:   next_state = CLEAR;
      CLEAR:   if (walk_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy_flag = (state != IDLE);
  end

  assign bus.busy = busy_flag;

  // The stage write and the clear walk never collide: nothing is accepted outside IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        counters[i] <= RESET_COUNT;
      stage_valid <= 1'b0;
      stage_index <= '0;
      stage_value <= RESET_COUNT;
      walk_idx    <= '0;
      priority_b  <= 1'b0;
    end else begin
      if (stage_valid)
        counters[stage_index] <= stage_value;
      if (state == CLEAR) begin
        counters[walk_idx] <= RESET_COUNT;
        walk_idx           <= walk_done ? '0 : walk_idx + DEPTH_LOG2'(1);
      end
      stage_valid <= fire_a || fire_b;
      stage_index <= req_index;
      stage_value <= new_value;
      if (contended)
        priority_b <= !priority_b;
    end
  end

  always_comb begin
`ifdef HYSTERESIS_COUNTER_TABLE_READ_BYPASS_EN
    read_value = (stage_valid && stage_index == bus.read_index) ? stage_value
                                                                : counters[bus.read_index];
`else
    read_value = counters[bus.read_index];
`endif
  end

  assign bus.read_count = read_value;
  assign bus.read_high  = (read_value >= HIGH_LIMIT);

endmodule

// File: tb/tb_hysteresis_counter_table_controller.sv
// Randomised and directed bench for hysteresis_counter_table_controller against a behavioural table model.
// The model tracks logical counter values, arbitration priority and busy time from the rules directly.
module tb_hysteresis_counter_table_controller;

  localparam int DEPTH       = 8;
  localparam int DEPTH_LOG2  = 3;
  localparam int RANGE       = 4;
  localparam int RANGE_LOG2  = 2;
  localparam int RESET_VALUE = 1;
  localparam int COERCIVITY  = 1;
`ifdef HYSTERESIS_COUNTER_TABLE_READ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  int m_tab [DEPTH];
  bit m_prio_b;
  int m_busy_left;
  bit m_last_valid;
  int m_last_idx;
  int m_last_old;

  hysteresis_counter_table_controller_if #(.DEPTH_LOG2(DEPTH_LOG2), .RANGE_LOG2(RANGE_LOG2)) bus ();

  hysteresis_counter_table_controller #(
    .DEPTH       (DEPTH),
    .DEPTH_LOG2  (DEPTH_LOG2),
    .RANGE       (RANGE),
    .RANGE_LOG2  (RANGE_LOG2),
    .RESET_VALUE (RESET_VALUE),
    .COERCIVITY  (COERCIVITY)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests_run++;
    if (observed != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic int stepModel(input int v, input bit up);
    if (up) begin
      if (v == RANGE / 2 - 1) return RANGE / 2 + COERCIVITY;
      return (v + 1 > RANGE - 1) ? RANGE - 1 : v + 1;
    end
    if (v == RANGE / 2) return RANGE / 2 - 1 - COERCIVITY;
    return (v == 0) ? 0 : v - 1;
  endfunction

  function automatic void resetModel();
    for (int i = 0; i < DEPTH; i++) m_tab[i] = RESET_VALUE;
    m_prio_b     = 1'b0;
    m_busy_left  = 0;
    m_last_valid = 1'b0;
    m_last_idx   = 0;
    m_last_old   = 0;
  endfunction

  // Drive one cycle of inputs, check at the falling edge, then advance the model past the rising edge.
  task automatic applyStimulus(input bit av, input int ai, input bit au,
                               input bit bv, input int bi, input bit bu,
                               input int ri, input bit clr);
    bit idle, same, ea, eb;
    int exp_read, idx, old;
    bus.update_a_valid = av;
    bus.update_a_index = DEPTH_LOG2'(ai);
    bus.update_a_up    = au;
    bus.update_b_valid = bv;
    bus.update_b_index = DEPTH_LOG2'(bi);
    bus.update_b_up    = bu;
    bus.read_index     = DEPTH_LOG2'(ri);
    bus.clear          = clr;
    @(negedge clock);
    idle = (m_busy_left == 0);
    same = (ai == bi);
    ea   = idle && !clr && av && (!bv || same || !m_prio_b);
    eb   = idle && !clr && bv && (!av || same || m_prio_b);
    checkOutput("ready_a", int'(bus.update_a_ready), int'(ea));
    checkOutput("ready_b", int'(bus.update_b_ready), int'(eb));
    checkOutput("busy", int'(bus.busy), int'(!idle));
    if (idle) begin
      if (!BYPASS && m_last_valid && m_last_idx == ri)
        exp_read = m_last_old;
      else
        exp_read = m_tab[ri];
      checkOutput("read_count", int'(bus.read_count), exp_read);
      checkOutput("read_high", int'(bus.read_high), int'(exp_read >= RANGE / 2));
    end
    m_last_valid = 1'b0;
    if (ea || eb) begin
      idx = ea ? ai : bi;
      old = m_tab[idx];
      if (ea && eb) begin
        if (au == bu) m_tab[idx] = stepModel(old, au);
      end else begin
        m_tab[idx] = stepModel(old, ea ? au : bu);
      end
      m_last_valid = 1'b1;
      m_last_idx   = idx;
      m_last_old   = old;
      if (av && bv && !same) m_prio_b = !m_prio_b;
    end
    if (m_busy_left > 0) begin
      m_busy_left--;
    end else if (clr) begin
      m_busy_left = DEPTH + 1;
      for (int i = 0; i < DEPTH; i++) m_tab[i] = RESET_VALUE;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic doReset(input int ri);
    reset              = 1'b1;
    bus.update_a_valid = 1'b1;
    bus.update_b_valid = 1'b1;
    bus.update_a_index = 3'd2;
    bus.update_b_index = 3'd5;
    bus.update_a_up    = 1'b1;
    bus.update_b_up    = 1'b0;
    bus.clear          = 1'b0;
    bus.read_index     = DEPTH_LOG2'(ri);
    @(posedge clock);
    #1;
    checkOutput("reset_ready_a", int'(bus.update_a_ready), 0);
    checkOutput("reset_ready_b", int'(bus.update_b_ready), 0);
    checkOutput("reset_busy", int'(bus.busy), 0);
    checkOutput("reset_read", int'(bus.read_count), RESET_VALUE);
    reset = 1'b0;
    resetModel();
  endtask

  initial begin
    bus.update_a_valid = 1'b0;
    bus.update_b_valid = 1'b0;
    bus.update_a_index = '0;
    bus.update_b_index = '0;
    bus.update_a_up    = 1'b0;
    bus.update_b_up    = 1'b0;
    bus.read_index     = '0;
    bus.clear          = 1'b0;
    resetModel();
    doReset(0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 0, 0, 0, i, 0);

    // Increments then decrements of index 3 across both jumps and both saturation points.
    for (int i = 0; i < 4; i++) applyStimulus(1, 3, 1, 0, 0, 0, 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 0);
    checkOutput("inc_saturate", int'(bus.read_count), 3);
    for (int i = 0; i < 4; i++) applyStimulus(1, 3, 0, 0, 0, 0, 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 0);
    checkOutput("dec_saturate", int'(bus.read_count), 0);

    // Contended different indices alternate grants.
    for (int i = 0; i < 4; i++) applyStimulus(1, 2, 1, 1, 5, 1, 2, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 5, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 5, 0);

    // Same-index merge: opposite directions cancel, equal directions step once.
    applyStimulus(1, 4, 1, 1, 4, 0, 4, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 4, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 4, 0);
    applyStimulus(1, 4, 1, 1, 4, 1, 4, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 4, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 4, 0);
    checkOutput("merge_single_step", int'(bus.read_count), 3);

    // Read latency after an update of index 6, then back-to-back chaining.
    applyStimulus(1, 6, 0, 0, 0, 0, 6, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 6, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 6, 0);
    applyStimulus(0, 0, 0, 1, 6, 1, 6, 0);
    applyStimulus(0, 0, 0, 1, 6, 1, 6, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 6, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 6, 0);

    // Clear with a pending stage; requests stay blocked during the walk.
    applyStimulus(1, 7, 1, 0, 0, 0, 7, 0);
    applyStimulus(1, 1, 1, 1, 2, 0, 7, 1);
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1, i, 1, 1, 7 - i, 0, i, 0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 0, 0, 0, i, 0);

    // Reset in the middle of a walk.
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    doReset(6);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 0, 0, 0, i, 0);

    for (int n = 0; n < 1500; n++) begin
      int ai, bi;
      ai = $urandom_range(0, DEPTH - 1);
      bi = ($urandom_range(0, 2) == 0) ? ai : $urandom_range(0, DEPTH - 1);
      applyStimulus($urandom_range(0, 2) != 0, ai, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 2) != 0, bi, $urandom_range(0, 1) == 1,
                    $urandom_range(0, DEPTH - 1), $urandom_range(0, 59) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
